// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps IF/ID/EX/MEM/WB and drives datapath enables/muxes.
// Latency (mem_ready high): 2-3 cycles for j/jal/jr/branch/illegal, 4 for R/I-ALU and store, 5 for load.
// Backpressure: holds in IF/MEM while mem_ready=0; aborts to IF with err after MEM_TIMEOUT wait cycles.
// Optional: define PERF_COUNTERS_EN to add cycle_count/instr_count outputs.
module mc_control_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ALUSrc,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        instr_done,
    output logic        err
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Last counter value before the wait is abandoned; unused when the timeout is disabled.
    localparam logic [15:0] TO_LAST = (MEM_TIMEOUT > 0) ? 16'(MEM_TIMEOUT - 1) : 16'd0;
    localparam bit          TO_EN   = (MEM_TIMEOUT > 0);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;

    logic w_is_rtype, w_is_jr, w_is_ialu, w_is_load, w_is_store;
    logic w_is_beq, w_is_bne, w_is_j, w_is_jal, w_decoded;
    logic w_waiting, w_timeout;

    logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write;
    logic       w_reg_write, w_instr_done, w_err;
    logic [1:0] w_pc_src, w_reg_dst, w_mem_to_reg;
    logic       w_i_or_d, w_alu_src;

    // Instruction class decode from the instruction register fields.
    always_comb begin
        w_is_rtype = (opcode == 6'h00);
        w_is_jr    = w_is_rtype && (funct == 6'h08);
        w_is_ialu  = (opcode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f});
        w_is_load  = (opcode inside {6'h23, 6'h24, 6'h25, 6'h30});
        w_is_store = (opcode inside {6'h28, 6'h29, 6'h2b, 6'h38});
        w_is_beq   = (opcode == 6'h04);
        w_is_bne   = (opcode == 6'h05);
        w_is_j     = (opcode == 6'h02);
        w_is_jal   = (opcode == 6'h03);
        w_decoded  = w_is_rtype | w_is_ialu | w_is_load | w_is_store | w_is_beq | w_is_bne;
    end

    // Memory wait tracking: only IF and MEM issue requests, so only they can stall or time out.
    always_comb begin
        w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;
        w_timeout = TO_EN && w_waiting && (r_wait_cnt == TO_LAST);
    end

    // Next-state and raw control outputs for the current step.
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_pc_src     = 2'd0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_i_or_d     = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'd0;
        w_mem_to_reg = 2'd0;
        w_instr_done = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_ID;
                end else if (w_timeout) begin
                    // PC was not advanced, so the refetch uses the same address.
                    w_err  = 1'b1;
                    w_next = S_IF;
                end
            end
            S_ID: begin
                if (w_is_j || w_is_jal) begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = 2'd2;
                    w_instr_done = 1'b1;
                    w_next       = S_IF;
                    if (w_is_jal) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = 2'd2;
                        w_mem_to_reg = 2'd2;
                    end
                end else if (w_decoded) begin
                    w_next = S_EX;
                end else begin
                    // Unknown opcode retires as a NOP with an error flag.
                    w_err        = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = S_IF;
                end
            end
            S_EX: begin
                if (w_is_jr) begin
                    w_pc_write   = 1'b1;
                    w_pc_src     = 2'd1;
                    w_instr_done = 1'b1;
                    w_next       = S_IF;
                end else if (w_is_rtype) begin
                    w_alu_src = 1'b0;
                    w_next    = S_WB;
                end else if (w_is_ialu) begin
                    w_alu_src = 1'b1;
                    w_next    = S_WB;
                end else if (w_is_load || w_is_store) begin
                    w_alu_src = 1'b1;
                    w_next    = S_MEM;
                end else if (w_is_beq || w_is_bne) begin
                    w_alu_src    = 1'b0;
                    w_pc_write   = w_is_beq ? Zero : !Zero;
                    w_pc_src     = 2'd1;
                    w_instr_done = 1'b1;
                    w_next       = S_IF;
                end else begin
                    w_next = S_IF;
                end
            end
            S_MEM: begin
                w_i_or_d    = 1'b1;
                w_mem_read  = w_is_load;
                w_mem_write = w_is_store;
                if (!(w_is_load || w_is_store)) begin
                    w_next = S_IF;
                end else if (mem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_instr_done = 1'b1;
                        w_next       = S_IF;
                    end
                end else if (w_timeout) begin
                    // Abort without touching the register file or PC.
                    w_err  = 1'b1;
                    w_next = S_IF;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_reg_dst    = w_is_rtype ? 2'd1 : 2'd0;
                w_mem_to_reg = w_is_load  ? 2'd1 : 2'd0;
                w_next       = S_IF;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // Drive ports; enables are forced low for the whole reset assertion, including the async edge.
    always_comb begin
        state      = r_state;
        pc_write   = w_pc_write   & ~reset;
        ir_write   = w_ir_write   & ~reset;
        mem_read   = w_mem_read   & ~reset;
        mem_write  = w_mem_write  & ~reset;
        reg_write  = w_reg_write  & ~reset;
        instr_done = w_instr_done & ~reset;
        err        = w_err        & ~reset;
        pc_src     = w_pc_src;
        i_or_d     = w_i_or_d;
        ALUSrc     = w_alu_src;
        reg_dst    = w_reg_dst;
        mem_to_reg = w_mem_to_reg;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter: counts stalled cycles, restarts on every state change or timeout abort.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 16'd0;
        end else if ((w_next != r_state) || w_timeout) begin
            r_wait_cnt <= 16'd0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

`ifdef PERF_COUNTERS_EN
    // Free-running cycle and retired-instruction counters, wrapping modulo 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            instr_count <= instr_count + 32'(w_instr_done);
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    localparam int D = -1;   // don't-care field

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [2:0] state;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, ALUSrc;
    logic       reg_write, instr_done, err;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count, instr_count;
`endif

    mc_control_fsm #(.RESET_STATE(3'd0), .MEM_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .Zero(Zero), .mem_ready(mem_ready), .state(state),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ALUSrc(ALUSrc), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .err(err)
`ifdef PERF_COUNTERS_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [17:0] exp;
        logic [17:0] msk;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Output order: state, pc_write, pc_src, ir_write, mem_read, mem_write,
    // i_or_d, ALUSrc, reg_write, reg_dst, mem_to_reg, instr_done, err.
    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy,
                       input int st, input int pcw, input int pcs, input int irw,
                       input int mr, input int mw, input int iod, input int als,
                       input int rw, input int rd, input int m2r, input int dn,
                       input int er, input string nm);
        vec_t v;
        int   f[13];
        int   w[13];
        f = '{st, pcw, pcs, irw, mr, mw, iod, als, rw, rd, m2r, dn, er};
        w = '{3, 1, 2, 1, 1, 1, 1, 1, 1, 2, 2, 1, 1};
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.name = nm;
        v.exp = '0; v.msk = '0;
        for (int i = 0; i < 13; i++) begin
            v.exp = (v.exp << w[i]) | ((f[i] < 0) ? 18'd0 : 18'(f[i]));
            v.msk = (v.msk << w[i]) | ((f[i] < 0) ? 18'd0 : 18'((1 << w[i]) - 1));
        end
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string nm);
        add(0, op, fn, 0, 1, 0, 1, 0, 1, 1, 0, 0, D, 0, D, D, 0, 0, nm);
    endtask

    task automatic decode(input logic [5:0] op, input logic [5:0] fn, input string nm);
        add(0, op, fn, 0, 1, 1, 0, D, 0, 0, 0, D, D, 0, D, D, 0, 0, nm);
    endtask

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {state, pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                ALUSrc, reg_write, reg_dst, mem_to_reg, instr_done, err};
    endfunction

    initial begin
        // Reset held three cycles with mem_ready high: all enables low.
        for (int i = 0; i < 3; i++)
            add(1, 6'h23, 0, 0, 1, 0, 0, D, 0, 0, 0, D, D, 0, D, D, 0, 0, "reset");
        // lw, no wait states: 5 cycles.
        fetch(6'h23, 0, "lw_if");
        decode(6'h23, 0, "lw_id");
        add(0, 6'h23, 0, 0, 1, 2, 0, D, 0, 0, 0, D, 1, 0, D, D, 0, 0, "lw_ex");
        add(0, 6'h23, 0, 0, 1, 3, 0, D, 0, 1, 0, 1, D, 0, D, D, 0, 0, "lw_mem");
        add(0, 6'h23, 0, 0, 1, 4, 0, D, 0, 0, 0, D, D, 1, 0, 1, 1, 0, "lw_wb");
        // sw with three MEM wait states.
        fetch(6'h2b, 0, "sw_if");
        decode(6'h2b, 0, "sw_id");
        add(0, 6'h2b, 0, 0, 1, 2, 0, D, 0, 0, 0, D, 1, 0, D, D, 0, 0, "sw_ex");
        for (int i = 0; i < 3; i++)
            add(0, 6'h2b, 0, 0, 0, 3, 0, D, 0, 0, 1, 1, D, 0, D, D, 0, 0, "sw_mem_wait");
        add(0, 6'h2b, 0, 0, 1, 3, 0, D, 0, 0, 1, 1, D, 0, D, D, 1, 0, "sw_mem_done");
        // beq taken, bne not taken (Zero=1 for both).
        fetch(6'h04, 0, "beq_if");
        decode(6'h04, 0, "beq_id");
        add(0, 6'h04, 0, 1, 1, 2, 1, 1, 0, 0, 0, D, 0, 0, D, D, 1, 0, "beq_ex");
        fetch(6'h05, 0, "bne_if");
        decode(6'h05, 0, "bne_id");
        add(0, 6'h05, 0, 1, 1, 2, 0, 1, 0, 0, 0, D, 0, 0, D, D, 1, 0, "bne_ex");
        // Illegal opcode.
        fetch(6'h3f, 0, "ill_if");
        add(0, 6'h3f, 0, 0, 1, 1, 0, D, 0, 0, 0, D, D, 0, D, D, 1, 1, "ill_id");
        // jal and j.
        fetch(6'h03, 0, "jal_if");
        add(0, 6'h03, 0, 0, 1, 1, 1, 2, 0, 0, 0, D, D, 1, 2, 2, 1, 0, "jal_id");
        fetch(6'h02, 0, "j_if");
        add(0, 6'h02, 0, 0, 1, 1, 1, 2, 0, 0, 0, D, D, 0, D, D, 1, 0, "j_id");
        // R-type add, jr, ori.
        fetch(6'h00, 6'h20, "add_if");
        decode(6'h00, 6'h20, "add_id");
        add(0, 6'h00, 6'h20, 0, 1, 2, 0, D, 0, 0, 0, D, 0, 0, D, D, 0, 0, "add_ex");
        add(0, 6'h00, 6'h20, 0, 1, 4, 0, D, 0, 0, 0, D, D, 1, 1, 0, 1, 0, "add_wb");
        fetch(6'h00, 6'h08, "jr_if");
        decode(6'h00, 6'h08, "jr_id");
        add(0, 6'h00, 6'h08, 0, 1, 2, 1, 1, 0, 0, 0, D, D, 0, D, D, 1, 0, "jr_ex");
        fetch(6'h0d, 0, "ori_if");
        decode(6'h0d, 0, "ori_id");
        add(0, 6'h0d, 0, 0, 1, 2, 0, D, 0, 0, 0, D, 1, 0, D, D, 0, 0, "ori_ex");
        add(0, 6'h0d, 0, 0, 1, 4, 0, D, 0, 0, 0, D, D, 1, 0, 0, 1, 0, "ori_wb");
        // IF timeout: err on the 16th stalled IF cycle, then a clean refetch.
        for (int i = 0; i < 15; i++)
            add(0, 6'h02, 0, 0, 0, 0, 0, D, 0, 1, 0, 0, D, 0, D, D, 0, 0, "if_wait");
        add(0, 6'h02, 0, 0, 0, 0, 0, D, 0, 1, 0, 0, D, 0, D, D, D, 1, "if_timeout");
        fetch(6'h02, 0, "if_refetch");
        add(0, 6'h02, 0, 0, 1, 1, 1, 2, 0, 0, 0, D, D, 0, D, D, 1, 0, "j_id2");
        // MEM timeout on a load: abort with err, no register write.
        fetch(6'h23, 0, "lwto_if");
        decode(6'h23, 0, "lwto_id");
        add(0, 6'h23, 0, 0, 1, 2, 0, D, 0, 0, 0, D, 1, 0, D, D, 0, 0, "lwto_ex");
        for (int i = 0; i < 15; i++)
            add(0, 6'h23, 0, 0, 0, 3, 0, D, 0, 1, 0, 1, D, 0, D, D, 0, 0, "lwto_wait");
        add(0, 6'h23, 0, 0, 0, 3, 0, D, 0, 1, 0, 1, D, 0, D, D, D, 1, "lwto_timeout");
        fetch(6'h23, 0, "lwto_after");

        foreach (vecs[k]) begin
            @(negedge clock);
            reset = vecs[k].rst; opcode = vecs[k].op; funct = vecs[k].fn;
            Zero = vecs[k].z; mem_ready = vecs[k].rdy;
            #1;
            chk(vecs[k].name, outs() & vecs[k].msk, vecs[k].exp & vecs[k].msk);
        end

        // Reset arriving mid-MEM on a store drops the write immediately.
        @(negedge clock); reset = 0; opcode = 6'h2b; funct = 0; mem_ready = 1;  // ID
        @(negedge clock);                                                        // EX
        @(negedge clock); mem_ready = 0;                                         // MEM
        #1;
        chk("midmem_state", {15'd0, state}, 18'd3);
        chk("midmem_write", {17'd0, mem_write}, 18'd1);
        #2 reset = 1;
        #1;
        chk("midmem_rst_write", {17'd0, mem_write}, 18'd0);
        chk("midmem_rst_state", {15'd0, state}, 18'd0);
        @(negedge clock); reset = 0; mem_ready = 1;
        #1;
        chk("post_rst_fetch", {15'd0, state, ir_write, pc_write, mem_read},
            {15'd0, 3'd0, 1'b1, 1'b1, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
